// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input NPN canonicalizer.
// The permutation table lists (pi(0),pi(1),pi(2),pi(3)) in lexicographic order.
package npn4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NUM_PERM  = 24;
   localparam int NUM_PHASE = 16;
   localparam int NUM_CAND  = NUM_PERM * NUM_PHASE;

   // Returns {pi(0), pi(1), pi(2), pi(3)}, pi(0) in the top two bits.
   function automatic logic [7:0] perm_digits(input logic [4:0] p);
      case (p)
         5'd0:    perm_digits = {2'd0, 2'd1, 2'd2, 2'd3};
         5'd1:    perm_digits = {2'd0, 2'd1, 2'd3, 2'd2};
         5'd2:    perm_digits = {2'd0, 2'd2, 2'd1, 2'd3};
         5'd3:    perm_digits = {2'd0, 2'd2, 2'd3, 2'd1};
         5'd4:    perm_digits = {2'd0, 2'd3, 2'd1, 2'd2};
         5'd5:    perm_digits = {2'd0, 2'd3, 2'd2, 2'd1};
         5'd6:    perm_digits = {2'd1, 2'd0, 2'd2, 2'd3};
         5'd7:    perm_digits = {2'd1, 2'd0, 2'd3, 2'd2};
         5'd8:    perm_digits = {2'd1, 2'd2, 2'd0, 2'd3};
         5'd9:    perm_digits = {2'd1, 2'd2, 2'd3, 2'd0};
         5'd10:   perm_digits = {2'd1, 2'd3, 2'd0, 2'd2};
         5'd11:   perm_digits = {2'd1, 2'd3, 2'd2, 2'd0};
         5'd12:   perm_digits = {2'd2, 2'd0, 2'd1, 2'd3};
         5'd13:   perm_digits = {2'd2, 2'd0, 2'd3, 2'd1};
         5'd14:   perm_digits = {2'd2, 2'd1, 2'd0, 2'd3};
         5'd15:   perm_digits = {2'd2, 2'd1, 2'd3, 2'd0};
         5'd16:   perm_digits = {2'd2, 2'd3, 2'd0, 2'd1};
         5'd17:   perm_digits = {2'd2, 2'd3, 2'd1, 2'd0};
         5'd18:   perm_digits = {2'd3, 2'd0, 2'd1, 2'd2};
         5'd19:   perm_digits = {2'd3, 2'd0, 2'd2, 2'd1};
         5'd20:   perm_digits = {2'd3, 2'd1, 2'd0, 2'd2};
         5'd21:   perm_digits = {2'd3, 2'd1, 2'd2, 2'd0};
         5'd22:   perm_digits = {2'd3, 2'd2, 2'd0, 2'd1};
         5'd23:   perm_digits = {2'd3, 2'd2, 2'd1, 2'd0};
         default: perm_digits = {2'd0, 2'd1, 2'd2, 2'd3};
      endcase
   endfunction

endpackage

// File: rtl/npn4_apply.sv
// Combinational NPN transform of a 4-input truth table:
// result[k] = neg ^ tt[m], with m_i = k_{pi(i)} ^ phase_i.
module npn4_apply
   import npn4_pkg::*;
(
   input  logic [15:0] tt,
   input  logic [4:0]  perm,
   input  logic [3:0]  phase,
   input  logic        neg,
   output logic [15:0] result
);

   logic [7:0] digits;
   logic [3:0] kb;
   logic [3:0] m;

   always_comb begin
      digits = perm_digits(perm);
      kb     = '0;
      m      = '0;
      result = '0;
      for (int k = 0; k < 16; k++) begin
         kb = 4'(k);
         for (int i = 0; i < 4; i++) begin
            m[i] = kb[digits[(3 - i) * 2 +: 2]] ^ phase[i];
         end
         result[k] = neg ^ tt[m];
      end
   end

endmodule

// File: rtl/npn4_canonizer.sv
// Sequential NPN canonicalizer: scans all 384 (perm, phase) pairs, one per cycle,
// folding output negation in by choosing the smaller of t and ~t.
module npn4_canonizer
   import npn4_pkg::*;
#(
   parameter int EARLY_EXIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_tt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_tt,
   output logic [4:0]  out_perm,
   output logic [3:0]  out_phase,
   output logic        out_neg
);

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
   // out_* stay stable while out_valid=1 until that transfer.
   state_t      state;
   logic [15:0] f_reg;
   logic [8:0]  idx;
   logic [15:0] best;
   logic        best_valid;
   logic [4:0]  best_perm;
   logic [3:0]  best_phase;
   logic        best_neg;

   logic [15:0] t;
   logic [15:0] cand;
   logic        cand_neg;
   logic        take;
   logic        exit_early;
   logic        last_idx;

   npn4_apply u_apply (
      .tt     (f_reg),
      .perm   (idx[8:4]),
      .phase  (idx[3:0]),
      .neg    (1'b0),
      .result (t)
   );

   // Strict compare keeps the first-found transform on ties; o=0 wins within one idx.
   assign cand_neg   = (~t < t);
   assign cand       = cand_neg ? ~t : t;
   assign take       = !best_valid || (cand < best);
   assign exit_early = (EARLY_EXIT != 0) && best_valid && (best == 16'h0000);
   assign last_idx   = (idx == 9'(NUM_CAND - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_tt     <= '0;
         out_perm   <= '0;
         out_phase  <= '0;
         out_neg    <= 1'b0;
         idx        <= '0;
         f_reg      <= '0;
         best       <= 16'hFFFF;
         best_valid <= 1'b0;
         best_perm  <= '0;
         best_phase <= '0;
         best_neg   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  f_reg      <= in_tt;
                  idx        <= '0;
                  best       <= 16'hFFFF;
                  best_valid <= 1'b0;
                  in_ready   <= 1'b0;
                  state      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (exit_early) begin
                  out_tt    <= best;
                  out_perm  <= best_perm;
                  out_phase <= best_phase;
                  out_neg   <= best_neg;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  if (take) begin
                     best       <= cand;
                     best_valid <= 1'b1;
                     best_perm  <= idx[8:4];
                     best_phase <= idx[3:0];
                     best_neg   <= cand_neg;
                  end
                  // The final candidate is folded straight into the outputs.
                  if (last_idx) begin
                     out_tt    <= take ? cand : best;
                     out_perm  <= take ? idx[8:4] : best_perm;
                     out_phase <= take ? idx[3:0] : best_phase;
                     out_neg   <= take ? cand_neg : best_neg;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     idx <= idx + 9'd1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_npn4_canonizer.sv
// Directed and random checks of npn4_canonizer, with an EARLY_EXIT=1 twin for latency.
module tb_npn4_canonizer;

   localparam int TIMEOUT = 1000;
   localparam int N_RAND  = 120;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, out_neg;
   logic [15:0] in_tt, out_tt;
   logic [4:0]  out_perm;
   logic [3:0]  out_phase;
   logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_out_neg;
   logic [15:0] e_in_tt, e_out_tt;
   logic [4:0]  e_out_perm;
   logic [3:0]  e_out_phase;

   int errors = 0;
   int checks = 0;

   npn4_canonizer #(.EARLY_EXIT(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tt(in_tt),
      .out_valid(out_valid), .out_ready(out_ready), .out_tt(out_tt),
      .out_perm(out_perm), .out_phase(out_phase), .out_neg(out_neg)
   );

   npn4_canonizer #(.EARLY_EXIT(1)) dut_ee (
      .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_tt(e_in_tt),
      .out_valid(e_out_valid), .out_ready(e_out_ready), .out_tt(e_out_tt),
      .out_perm(e_out_perm), .out_phase(e_out_phase), .out_neg(e_out_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: permutations generated by nested loops (lexicographic).
   function automatic void ref_canon(input logic [15:0] f, output logic [15:0] bt,
                                     output logic [4:0] bp, output logic [3:0] bph,
                                     output logic bn);
      int pi[4];
      int p;
      bit found;
      logic [15:0] t, c;
      logic [3:0] m;
      p = 0; found = 0; bt = 16'hFFFF; bp = '0; bph = '0; bn = 1'b0;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int cc = 0; cc < 4; cc++)
               for (int d = 0; d < 4; d++) begin
                  if (a != b && a != cc && a != d && b != cc && b != d && cc != d) begin
                     pi[0] = a; pi[1] = b; pi[2] = cc; pi[3] = d;
                     for (int ph = 0; ph < 16; ph++) begin
                        for (int k = 0; k < 16; k++) begin
                           for (int i = 0; i < 4; i++)
                              m[i] = 1'(((k >> pi[i]) & 1) ^ ((ph >> i) & 1));
                           t[k] = f[m];
                        end
                        c = (~t < t) ? ~t : t;
                        if (!found || c < bt) begin
                           found = 1; bt = c; bp = 5'(p); bph = 4'(ph); bn = (~t < t);
                        end
                     end
                     p++;
                  end
               end
   endfunction

   task automatic run_one(input logic [15:0] tt, input bit ack, output logic [15:0] r_tt,
                          output logic [4:0] r_perm, output logic [3:0] r_phase,
                          output logic r_neg, output int lat);
      int n;
      @(negedge clk);
      in_tt = tt; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      lat = out_valid ? n : -1;
      r_tt = out_tt; r_perm = out_perm; r_phase = out_phase; r_neg = out_neg;
      if (ack) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic run_one_ee(input logic [15:0] tt, output logic [15:0] r_tt,
                             output logic [4:0] r_perm, output logic [3:0] r_phase,
                             output logic r_neg, output int lat);
      int n;
      @(negedge clk);
      e_in_tt = tt; e_in_valid = 1'b1;
      @(negedge clk);
      e_in_valid = 1'b0;
      n = 0;
      while (!e_out_valid && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      lat = e_out_valid ? n : -1;
      r_tt = e_out_tt; r_perm = e_out_perm; r_phase = e_out_phase; r_neg = e_out_neg;
      e_out_ready = 1'b1;
      @(negedge clk);
      e_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      checks++;
      if (out_tt !== 16'h0 || out_perm !== 5'd0 || out_phase !== 4'h0 || out_neg !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: tt=%h perm=%0d phase=%h neg=%b expected 0000 0 0 0",
                  out_tt, out_perm, out_phase, out_neg);
      end
      checks++;
      if (e_in_ready !== 1'b1 || e_out_valid !== 1'b0 || e_out_tt !== 16'h0) begin
         errors++;
         $display("FAIL reset_ee: in_ready=%b out_valid=%b tt=%h expected 1 0 0000",
                  e_in_ready, e_out_valid, e_out_tt);
      end
   endtask

   task automatic test_directed();
      logic [15:0] v_in [8] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h8888,
                                16'h5555, 16'h8000, 16'h7FFF, 16'h6666};
      logic [15:0] v_tt [8] = '{16'h0000, 16'h0000, 16'h00FF, 16'h000F,
                                16'h00FF, 16'h0001, 16'h0001, 16'h0FF0};
      logic [4:0]  v_pm [8] = '{5'd0, 5'd0, 5'd18, 5'd16, 5'd18, 5'd0, 5'd0, 5'd16};
      logic [3:0]  v_ph [8] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'hF, 4'hF, 4'h0};
      logic        v_ng [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] r_tt; logic [4:0] r_pm; logic [3:0] r_ph; logic r_ng; int lat;
      for (int i = 0; i < 8; i++) begin
         run_one(v_in[i], 1'b1, r_tt, r_pm, r_ph, r_ng, lat);
         checks++;
         if (r_tt !== v_tt[i] || r_pm !== v_pm[i] || r_ph !== v_ph[i] || r_ng !== v_ng[i]) begin
            errors++;
            $display("FAIL directed_%h: got tt=%h perm=%0d phase=%h neg=%b expected %h %0d %h %b",
                     v_in[i], r_tt, r_pm, r_ph, r_ng, v_tt[i], v_pm[i], v_ph[i], v_ng[i]);
         end
         checks++;
         if (lat != 384) begin
            errors++;
            $display("FAIL latency_%h: got %0d expected 384", v_in[i], lat);
         end
      end
   endtask

   task automatic test_early_exit();
      logic [15:0] v_in [4] = '{16'hFFFF, 16'h0000, 16'hAAAA, 16'h8888};
      logic [15:0] v_tt [4] = '{16'h0000, 16'h0000, 16'h00FF, 16'h000F};
      logic [4:0]  v_pm [4] = '{5'd0, 5'd0, 5'd18, 5'd16};
      logic [3:0]  v_ph [4] = '{4'h0, 4'h0, 4'h0, 4'h3};
      logic        v_ng [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      int          v_lt [4] = '{2, 2, 384, 384};
      logic [15:0] r_tt; logic [4:0] r_pm; logic [3:0] r_ph; logic r_ng; int lat;
      for (int i = 0; i < 4; i++) begin
         run_one_ee(v_in[i], r_tt, r_pm, r_ph, r_ng, lat);
         checks++;
         if (r_tt !== v_tt[i] || r_pm !== v_pm[i] || r_ph !== v_ph[i] || r_ng !== v_ng[i]) begin
            errors++;
            $display("FAIL early_%h: got tt=%h perm=%0d phase=%h neg=%b expected %h %0d %h %b",
                     v_in[i], r_tt, r_pm, r_ph, r_ng, v_tt[i], v_pm[i], v_ph[i], v_ng[i]);
         end
         checks++;
         if (lat != v_lt[i]) begin
            errors++;
            $display("FAIL early_lat_%h: got %0d expected %0d", v_in[i], lat, v_lt[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] r_tt; logic [4:0] r_pm; logic [3:0] r_ph; logic r_ng; int lat;
      run_one(16'h8888, 1'b0, r_tt, r_pm, r_ph, r_ng, lat);
      checks++;
      if (r_tt !== 16'h000F || r_pm !== 5'd16 || r_ph !== 4'h3 || r_ng !== 1'b0 || lat != 384) begin
         errors++;
         $display("FAIL bp_result: got tt=%h perm=%0d phase=%h neg=%b lat=%0d expected 000f 16 3 0 384",
                  r_tt, r_pm, r_ph, r_ng, lat);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         in_tt = 16'hFFFF;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tt !== 16'h000F ||
             out_perm !== 5'd16 || out_phase !== 4'h3 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%b ready=%b tt=%h perm=%0d phase=%h neg=%b expected 1 0 000f 16 3 0",
                     i, out_valid, in_ready, out_tt, out_perm, out_phase, out_neg);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] r_tt; logic [4:0] r_pm; logic [3:0] r_ph; logic r_ng; int lat;
      int n;
      run_one(16'hAAAA, 1'b1, r_tt, r_pm, r_ph, r_ng, lat);
      checks++;
      if (r_tt !== 16'h00FF || r_pm !== 5'd18 || r_ph !== 4'h0 || r_ng !== 1'b1 || lat != 384) begin
         errors++;
         $display("FAIL b2b_next: got tt=%h perm=%0d phase=%h neg=%b lat=%0d expected 00ff 18 0 1 384",
                  r_tt, r_pm, r_ph, r_ng, lat);
      end
      // Ack and present a new input in the same DONE cycle.
      run_one(16'h6666, 1'b0, r_tt, r_pm, r_ph, r_ng, lat);
      out_ready = 1'b1; in_valid = 1'b1; in_tt = 16'hFFFF;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_accept: in_ready=%b expected 0", in_ready);
      end
      n = 0;
      while (!out_valid && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 384 || out_tt !== 16'h0000 || out_perm !== 5'd0 || out_phase !== 4'h0 || out_neg !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_result: lat=%0d tt=%h perm=%0d phase=%h neg=%b expected 384 0000 0 0 1",
                  n, out_tt, out_perm, out_phase, out_neg);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      logic [15:0] r_tt; logic [4:0] r_pm; logic [3:0] r_ph; logic r_ng; int lat;
      @(negedge clk);
      in_tt = 16'h8888; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_scan_busy: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_tt !== 16'h0 || out_perm !== 5'd0 ||
          out_phase !== 4'h0 || out_neg !== 1'b0) begin
         errors++;
         $display("FAIL mid_scan_rst: ready=%b valid=%b tt=%h perm=%0d phase=%h neg=%b expected 1 0 0000 0 0 0",
                  in_ready, out_valid, out_tt, out_perm, out_phase, out_neg);
      end
      @(negedge clk);
      rst = 1'b0;
      run_one(16'hAAAA, 1'b1, r_tt, r_pm, r_ph, r_ng, lat);
      checks++;
      if (r_tt !== 16'h00FF || r_pm !== 5'd18 || r_ph !== 4'h0 || r_ng !== 1'b1 || lat != 384) begin
         errors++;
         $display("FAIL after_rst: got tt=%h perm=%0d phase=%h neg=%b lat=%0d expected 00ff 18 0 1 384",
                  r_tt, r_pm, r_ph, r_ng, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] f, r_tt, x_tt; logic [4:0] r_pm, x_pm; logic [3:0] r_ph, x_ph;
      logic r_ng, x_ng; int lat;
      for (int i = 0; i < N_RAND; i++) begin
         f = 16'($urandom_range(0, 65535));
         ref_canon(f, x_tt, x_pm, x_ph, x_ng);
         run_one(f, 1'b1, r_tt, r_pm, r_ph, r_ng, lat);
         checks++;
         if (r_tt !== x_tt || r_pm !== x_pm || r_ph !== x_ph || r_ng !== x_ng || lat != 384) begin
            errors++;
            $display("FAIL random_%h: got tt=%h perm=%0d phase=%h neg=%b lat=%0d expected %h %0d %h %b 384",
                     f, r_tt, r_pm, r_ph, r_ng, lat, x_tt, x_pm, x_ph, x_ng);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_tt = '0; out_ready = 1'b0;
      e_in_valid = 1'b0; e_in_tt = '0; e_out_ready = 1'b0;
      test_reset();
      test_directed();
      test_early_exit();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
